// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants, descriptor type and FSM encoding for the DMA command sequencer
package dma_pkg;

   // Register offsets relative to the DMA register base
   localparam logic [15:0] DMA_REG_START = 16'd0;
   localparam logic [15:0] SRC_LO        = 16'd1;
   localparam logic [15:0] SRC_HI        = 16'd2;
   localparam logic [15:0] DST_LO        = 16'd3;
   localparam logic [15:0] DST_HI        = 16'd4;
   localparam logic [15:0] NBYTES        = 16'd5;

   // Address driven on the aux bus when no register access is in progress
   localparam logic [15:0] AUX_IDLE_ADDR = 16'h0000;

   // Descriptor layout: src, dst, size code
   localparam int DESC_W = 40;

   typedef struct packed {
      logic [15:0] src;
      logic [15:0] dst;
      logic [7:0]  n;
   } desc_t;

   // Index of the final write of a descriptor (the start strobe)
   localparam logic [2:0] LAST_IDX = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WRITE    = 3'd2,
      ST_WAIT_IRQ = 3'd3,
      ST_ACK      = 3'd4,
      ST_GAP      = 3'd5
   } seq_state_t;

   // Write order: src lo/hi, dst lo/hi, size, then start last so the dma sees a complete setup
   function automatic logic [15:0] reg_offset(input logic [2:0] idx);
      logic [15:0] off;
      case (idx)
         3'd0:    off = SRC_LO;
         3'd1:    off = SRC_HI;
         3'd2:    off = DST_LO;
         3'd3:    off = DST_HI;
         3'd4:    off = NBYTES;
         default: off = DMA_REG_START;
      endcase
      return off;
   endfunction

   function automatic logic [7:0] reg_data(input logic [2:0] idx, input desc_t d);
      logic [7:0] v;
      case (idx)
         3'd0:    v = d.src[7:0];
         3'd1:    v = d.src[15:8];
         3'd2:    v = d.dst[7:0];
         3'd3:    v = d.dst[15:8];
         3'd4:    v = d.n;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/desc_fifo.sv
// rtl/desc_fifo.sv - synchronous descriptor FIFO with occupancy count
module desc_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage array; contents need no reset because empty gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_cmd_sequencer.sv
// rtl/dma_cmd_sequencer.sv - descriptor queue and aux-bus initiator that programs and starts the dma
module dma_cmd_sequencer
   import dma_pkg::*;
#(
   parameter logic [15:0] DMA_BASE    = 16'h0100,
   parameter int          HOLD_CYCLES = 2,
   parameter int          DEPTH       = 4,
   parameter int          TIMEOUT     = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   input  logic [15:0]              desc_src,
   input  logic [15:0]              desc_dst,
   input  logic [7:0]               desc_n,
   output logic [15:0]              auxdaddr,
   output logic [7:0]               auxdin,
   input  logic                     irq,
   output logic                     ack,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX   = '1;

   seq_state_t     state, state_n;
   logic [2:0]     idx, idx_n;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic [TW-1:0]  timer, timer_n;
   desc_t          work, work_n;

   logic [15:0]    addr_n;
   logic [7:0]     din_n;
   logic           ack_n;
   logic           timeout_n;

   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [DESC_W-1:0] fifo_din;
   logic [DESC_W-1:0] fifo_dout;
   desc_t          head;

   assign desc_ready = !fifo_full;
   assign fifo_push  = desc_valid && desc_ready;
   assign fifo_din   = {desc_src, desc_dst, desc_n};
   assign head       = fifo_dout;
   assign busy       = (state != ST_IDLE) || !fifo_empty;

   desc_fifo #(
      .WIDTH (DESC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Next state and next registered bus outputs; the bus value for the following cycle is decided here
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      hold_n    = hold_cnt;
      timer_n   = timer;
      work_n    = work;
      fifo_pop  = 1'b0;
      addr_n    = AUX_IDLE_ADDR;
      din_n     = 8'h00;
      ack_n     = 1'b0;
      timeout_n = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_n = ST_LOAD;
            end
         end
         ST_LOAD: begin
            fifo_pop = 1'b1;
            work_n   = head;
            idx_n    = 3'd0;
            hold_n   = '0;
            state_n  = ST_WRITE;
            addr_n   = DMA_BASE + reg_offset(3'd0);
            din_n    = reg_data(3'd0, head);
         end
         ST_WRITE: begin
            if (hold_cnt == HOLD_LAST) begin
               if (idx == LAST_IDX) begin
                  state_n = ST_WAIT_IRQ;
                  timer_n = '0;
               end else begin
                  idx_n  = idx + 3'd1;
                  hold_n = '0;
                  addr_n = DMA_BASE + reg_offset(idx + 3'd1);
                  din_n  = reg_data(idx + 3'd1, work);
               end
            end else begin
               hold_n = hold_cnt + 1'b1;
               addr_n = DMA_BASE + reg_offset(idx);
               din_n  = reg_data(idx, work);
            end
         end
         ST_WAIT_IRQ: begin
            if (irq) begin
               state_n = ST_ACK;
               ack_n   = 1'b1;
            end else if (timer == TMO_LAST) begin
               state_n   = ST_GAP;
               timeout_n = 1'b1;
            end else if (timer != TMO_MAX) begin
               timer_n = timer + 1'b1;
            end
         end
         ST_ACK: begin
            state_n = ST_GAP;
         end
         ST_GAP: begin
            state_n = fifo_empty ? ST_IDLE : ST_LOAD;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Working descriptor, write index, hold counter and irq wait timer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx      <= 3'd0;
         hold_cnt <= '0;
         timer    <= '0;
         work     <= '0;
      end else begin
         idx      <= idx_n;
         hold_cnt <= hold_n;
         timer    <= timer_n;
         work     <= work_n;
      end
   end

   // Registered outputs toward the dma and the host
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         auxdaddr <= AUX_IDLE_ADDR;
         auxdin   <= 8'h00;
         ack      <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         auxdaddr <= addr_n;
         auxdin   <= din_n;
         ack      <= ack_n;
         done     <= ack_n;
         timeout  <= timeout_n;
      end
   end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// tb/tb_dma_cmd_sequencer.sv - directed self-checking bench for dma_cmd_sequencer
module tb_dma_cmd_sequencer;

   logic        clk;
   logic        rst;
   logic        desc_valid;
   logic        desc_ready;
   logic [15:0] desc_src;
   logic [15:0] desc_dst;
   logic [7:0]  desc_n;
   logic [15:0] auxdaddr;
   logic [7:0]  auxdin;
   logic        irq;
   logic        ack;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [2:0]  level;

   int checks;
   int errors;

   dma_cmd_sequencer #(
      .DMA_BASE    (16'h0100),
      .HOLD_CYCLES (2),
      .DEPTH       (4),
      .TIMEOUT     (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_src   (desc_src),
      .desc_dst   (desc_dst),
      .desc_n     (desc_n),
      .auxdaddr   (auxdaddr),
      .auxdin     (auxdin),
      .irq        (irq),
      .ack        (ack),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
      desc_src   = s;
      desc_dst   = d;
      desc_n     = n;
      desc_valid = 1'b1;
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic wait_aux(input logic [15:0] a, input int budget, input string tag);
      int k;
      k = 0;
      while (auxdaddr !== a && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (auxdaddr !== a) begin
         errors++;
         $display("FAIL %s: auxdaddr=%h required %h within %0d cycles", tag, auxdaddr, a, budget);
      end
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      irq = 1'b1;
      while (busy && k < 400) begin
         tick();
         k++;
      end
      irq = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s drain: busy=%b required 0", tag, busy);
      end
   endtask

   task automatic run_single(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                             input string tag);
      logic [15:0] ea [6];
      logic [7:0]  ed [6];
      ea = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0100};
      ed[0] = s[7:0];
      ed[1] = s[15:8];
      ed[2] = d[7:0];
      ed[3] = d[15:8];
      ed[4] = n;
      ed[5] = 8'h00;
      push(s, d, n);
      checks++;
      if (auxdaddr !== 16'h0000) begin
         errors++;
         $display("FAIL %s idle cycle: auxdaddr=%h required 0000", tag, auxdaddr);
      end
      tick();
      checks++;
      if (auxdaddr !== 16'h0000) begin
         errors++;
         $display("FAIL %s load cycle: auxdaddr=%h required 0000", tag, auxdaddr);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (auxdaddr !== ea[i/2] || auxdin !== ed[i/2]) begin
            errors++;
            $display("FAIL %s write cycle %0d: addr=%h din=%h required addr=%h din=%h",
                     tag, i, auxdaddr, auxdin, ea[i/2], ed[i/2]);
         end
      end
      tick();
      checks++;
      if (auxdaddr !== 16'h0000 || auxdin !== 8'h00 || ack !== 1'b0) begin
         errors++;
         $display("FAIL %s post-write: addr=%h din=%h ack=%b required 0000 00 0",
                  tag, auxdaddr, auxdin, ack);
      end
      irq = 1'b1;
      tick();
      irq = 1'b0;
      checks++;
      if (ack !== 1'b1 || done !== 1'b1) begin
         errors++;
         $display("FAIL %s ack: ack=%b done=%b required 1 1", tag, ack, done);
      end
      tick();
      checks++;
      if (ack !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s ack width: ack=%b done=%b required 0 0", tag, ack, done);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle after gap: busy=%b required 0", tag, busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (auxdaddr !== 16'h0000 || auxdin !== 8'h00 || ack !== 1'b0 || done !== 1'b0 ||
          timeout !== 1'b0 || busy !== 1'b0 || level !== 3'd0) begin
         errors++;
         $display("FAIL reset values: addr=%h din=%h ack=%b done=%b tmo=%b busy=%b level=%0d required all zero",
                  auxdaddr, auxdin, ack, done, timeout, busy, level);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (desc_ready !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset release: ready=%b level=%0d busy=%b required 1 0 0",
                  desc_ready, level, busy);
      end
   endtask

   task automatic test_single;
      run_single(16'h0020, 16'h0030, 8'h03, "single");
   endtask

   task automatic test_spurious_irq;
      irq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ack !== 1'b0 || done !== 1'b0 || auxdaddr !== 16'h0000) begin
            errors++;
            $display("FAIL spurious irq cycle %0d: ack=%b done=%b addr=%h required 0 0 0000",
                     i, ack, done, auxdaddr);
         end
      end
      irq = 1'b0;
   endtask

   task automatic test_queue_full;
      push(16'h0001, 16'h0002, 8'h03);
      wait_aux(16'h0100, 40, "qfull start");
      wait_aux(16'h0000, 10, "qfull wait entry");
      for (int i = 0; i < 4; i++) begin
         push(16'h1000 + 16'(i), 16'h2000 + 16'(i), 8'(i));
      end
      checks++;
      if (level !== 3'd4 || desc_ready !== 1'b0) begin
         errors++;
         $display("FAIL qfull full: level=%0d ready=%b required 4 0", level, desc_ready);
      end
      push(16'hDEAD, 16'hBEEF, 8'hEE);
      checks++;
      if (level !== 3'd4) begin
         errors++;
         $display("FAIL qfull fifth push: level=%0d required 4", level);
      end
      irq = 1'b1;
      tick();
      irq = 1'b0;
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL qfull ack: ack=%b required 1", ack);
      end
      tick();
      tick();
      checks++;
      if (desc_ready !== 1'b0) begin
         errors++;
         $display("FAIL qfull ready before pop: ready=%b required 0", desc_ready);
      end
      tick();
      checks++;
      if (level !== 3'd3 || desc_ready !== 1'b1) begin
         errors++;
         $display("FAIL qfull after pop: level=%0d ready=%b required 3 1", level, desc_ready);
      end
      drain("qfull");
   endtask

   task automatic test_back_to_back;
      push(16'h0040, 16'h0050, 8'h01);
      push(16'h1122, 16'h3344, 8'h02);
      wait_aux(16'h0100, 40, "b2b start");
      wait_aux(16'h0000, 10, "b2b wait entry");
      repeat (4) tick();
      irq = 1'b1;
      tick();
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL b2b ack: ack=%b required 1", ack);
      end
      irq = 1'b0;
      tick();
      checks++;
      if (auxdaddr !== 16'h0000) begin
         errors++;
         $display("FAIL b2b gap: auxdaddr=%h required 0000", auxdaddr);
      end
      tick();
      checks++;
      if (auxdaddr !== 16'h0000) begin
         errors++;
         $display("FAIL b2b load: auxdaddr=%h required 0000", auxdaddr);
      end
      tick();
      checks++;
      if (auxdaddr !== 16'h0101 || auxdin !== 8'h22) begin
         errors++;
         $display("FAIL b2b second first write: addr=%h din=%h required 0101 22", auxdaddr, auxdin);
      end
      drain("b2b");
   endtask

   task automatic test_timeout;
      logic early;
      push(16'h0200, 16'h0300, 8'h0F);
      push(16'h0A0B, 16'h0C0D, 8'h01);
      wait_aux(16'h0100, 40, "tmo start");
      wait_aux(16'h0000, 10, "tmo wait entry");
      early = 1'b0;
      for (int i = 1; i < 64; i++) begin
         tick();
         if (timeout !== 1'b0 || ack !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL tmo early: pulse seen=%b required 0 before cycle 64", early);
      end
      tick();
      checks++;
      if (timeout !== 1'b1 || ack !== 1'b0) begin
         errors++;
         $display("FAIL tmo pulse: timeout=%b ack=%b required 1 0", timeout, ack);
      end
      tick();
      checks++;
      if (timeout !== 1'b0 || auxdaddr !== 16'h0000) begin
         errors++;
         $display("FAIL tmo after pulse: timeout=%b addr=%h required 0 0000", timeout, auxdaddr);
      end
      tick();
      checks++;
      if (auxdaddr !== 16'h0101 || auxdin !== 8'h0B) begin
         errors++;
         $display("FAIL tmo next desc: addr=%h din=%h required 0101 0B", auxdaddr, auxdin);
      end
      drain("tmo");
   endtask

   task automatic test_timeout_irq_race;
      push(16'h0300, 16'h0400, 8'h07);
      wait_aux(16'h0100, 40, "race start");
      wait_aux(16'h0000, 10, "race wait entry");
      repeat (63) tick();
      irq = 1'b1;
      tick();
      irq = 1'b0;
      checks++;
      if (ack !== 1'b1 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL race expiry: ack=%b timeout=%b required 1 0", ack, timeout);
      end
      tick();
      checks++;
      if (ack !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL race after: ack=%b timeout=%b required 0 0", ack, timeout);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL race idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_mid_write;
      push(16'h5566, 16'h7788, 8'h09);
      push(16'h99AA, 16'hBBCC, 8'h0D);
      wait_aux(16'h0103, 40, "rstmid idx2");
      checks++;
      if (level !== 3'd1) begin
         errors++;
         $display("FAIL rstmid queued: level=%0d required 1", level);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (auxdaddr !== 16'h0000 || auxdin !== 8'h00 || level !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid async: addr=%h din=%h level=%0d busy=%b required 0000 00 0 0",
                  auxdaddr, auxdin, level, busy);
      end
      tick();
      rst = 1'b1;
      tick();
      run_single(16'hABCD, 16'h1234, 8'h7F, "after reset");
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      desc_valid = 1'b0;
      desc_src   = 16'h0000;
      desc_dst   = 16'h0000;
      desc_n     = 8'h00;
      irq        = 1'b0;
      test_reset();
      test_single();
      test_spurious_irq();
      test_queue_full();
      test_back_to_back();
      test_timeout();
      test_timeout_irq_race();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_cmd_sequencer.md
Name: dma_cmd_sequencer

Overview:
- Hardware command queue and core-side initiator for the DMA auxiliary register bus.
- Accepts transfer descriptors (src, dst, n) through a ready/valid port and buffers them in a FIFO.
- For each descriptor: programs the DMA register file over auxdaddr/auxdin, issues start, waits for irq, then answers with a one-cycle ack.
- Sits between a host agent (core or accelerator) and the dma block, replacing software-driven register programming.

Parameters:
- DMA_BASE, 16'h0100, DMA register base. Offsets: +0 start, +1 src lo, +2 src hi, +3 dst lo, +4 dst hi, +5 n.
- HOLD_CYCLES, 2, cycles each register write is held on the aux bus (≥1).
- DEPTH, 4, descriptor FIFO depth (power of 2, ≥2).
- TIMEOUT, 1024, max cycles waiting for irq before abandoning a descriptor.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (rst=0 resets).
- desc_valid  input  1  descriptor offered.
- desc_ready  output  1  FIFO can accept (= not full).
- desc_src  input  16  source address.
- desc_dst  input  16  destination address.
- desc_n  input  8  size code; bytes = (n+1)<<shift of dma.
- auxdaddr  output  16  register address to dma; 16'h0000 = no access.
- auxdin  output  8  register write data to dma.
- irq  input  1  dma transfer-complete interrupt.
- ack  output  1  interrupt acknowledge to dma.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- done  output  1  one-cycle pulse, coincident with ack.
- timeout  output  1  one-cycle pulse on irq wait expiry.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: FIFO flushed, level=0, FSM IDLE. auxdaddr=0, auxdin=0, ack=0, done=0, timeout=0, busy=0. desc_ready=1 once rst=1.
- All outputs are registered except desc_ready, busy and level.
- Push: accepted on a rising edge with desc_valid&&desc_ready. desc_ready=0 when level==DEPTH, even if a pop happens in the same cycle. Simultaneous push and pop are allowed when not full; level is unchanged.
- FSM states: IDLE, LOAD, WRITE, WAIT_IRQ, ACK, GAP.
- IDLE: if FIFO non-empty, go to LOAD; otherwise auxdaddr=0.
- LOAD: pop the head into working registers, idx=0, hold counter=0, go to WRITE.
  - Latency: the first write appears on auxdaddr in the second cycle after the push-accepting edge, when the FIFO was empty and the FSM was IDLE.
- WRITE: drive auxdaddr/auxdin for idx 0..5 in fixed order, each for exactly HOLD_CYCLES cycles:
  - idx 0: DMA_BASE+1 / src[7:0]
  - idx 1: DMA_BASE+2 / src[15:8]
  - idx 2: DMA_BASE+3 / dst[7:0]
  - idx 3: DMA_BASE+4 / dst[15:8]
  - idx 4: DMA_BASE+5 / n
  - idx 5: DMA_BASE+0 / 8'h00 (start)
  - Write phase totals 6*HOLD_CYCLES cycles, with no gaps between writes. After idx 5, auxdaddr=0 and auxdin=0 on the next cycle; go to WAIT_IRQ.
- WAIT_IRQ: timer counts cycles from entry.
  - irq=1 → ACK.
  - Timer reaches TIMEOUT−1 with irq low → pulse timeout, go to GAP without ack.
  - irq and expiry in the same cycle: irq wins.
- ACK: ack=1 and done=1 for exactly one cycle, then GAP.
- GAP: one cycle with auxdaddr=0 and ack=0, letting dma drop irq. Then go to IDLE, or LOAD if the FIFO is non-empty; back-to-back descriptors need no extra IDLE cycle.
- irq outside WAIT_IRQ is ignored; ack is never asserted outside ACK.
- Reset mid-operation (any state): immediate return to reset values, and queued descriptors are lost. The caller must also reset the dma.
- TIMEOUT timer width: $clog2(TIMEOUT)+1, saturating; no wrap.
- level never exceeds DEPTH. FIFO pointers wrap modulo DEPTH.

Decomposition:
- Shared package dma_pkg:
  - Register offset constants: DMA_REG_START=0, SRC_LO=1, SRC_HI=2, DST_LO=3, DST_HI=4, NBYTES=5.
  - Idle address constant 16'h0000.
  - Descriptor struct/width constant (40 bits: src, dst, n).
  - FSM state encoding (3 bits).
- Sub-module desc_fifo: synchronous FIFO, WIDTH=40, DEPTH param; ports push, pop, din, dout, full, empty, level. Same clk/rst.

Test Plan:
- Single transfer: push src=0x0020, dst=0x0030, n=3.
  - Expect auxdaddr/auxdin pairs 0101/20, 0102/00, 0103/30, 0104/00, 0105/03, 0100/00, each for 2 cycles, then 0000.
  - With the dma and DRAM attached: irq, then one-cycle ack+done. DRAM 0x0030–0x003F equals preloaded 0x0020–0x002F (0x10 down to 0x01).
- Queue full: with FSM stalled in WAIT_IRQ, push 4 descriptors after the active one.
  - level=4 and desc_ready=0; a 5th valid is not accepted.
  - After ack and pop, desc_ready=1.
- Back-to-back: two queued descriptors; irq is a mock asserted 5 cycles after start and cleared on ack.
  - Second descriptor's 0x0101 write begins exactly 2 cycles after ack (GAP, LOAD).
- Timeout: TIMEOUT=64, irq held low.
  - timeout pulses 64 cycles after WAIT_IRQ entry; no ack; next descriptor proceeds.
  - Separately, irq=1 on the expiry cycle → ack, no timeout pulse.
- Reset mid-write: assert rst=0 during idx 2.
  - Outputs return to 0 asynchronously; level=0 and busy=0.
  - After release, a new push produces a full, correct sequence.
- Spurious irq in IDLE: irq=1 for 3 cycles with an empty FIFO → ack stays 0, done stays 0.
